// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types, defaults and sizing helper for the instruction fetch unit.
//   ifu_state_t  : fetch FSM states (IDLE, FETCH, FLUSH)
//   ifu_entry_t  : prefetch queue entry {pc, instr}
//   IFU_RESET_PC : default first fetch address
//   IFU_DEPTH    : default prefetch queue depth / credit limit
//   ifu_cnt_w()  : width of a counter able to hold 0..depth
package ifu_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} ifu_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifu_entry_t;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
    localparam int          IFU_DEPTH    = 4;

    function automatic int ifu_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifu_if.sv
// ifu_if: handshake bundle between the fetch unit, instruction memory, the redirect source and decode.
//   imem_req_valid/ready/addr : fetch request channel (fetch unit -> memory)
//   imem_rsp_valid/data       : in-order response channel (memory -> fetch unit)
//   redirect_valid/pc         : branch/jump redirect (datapath -> fetch unit)
//   instr_valid/ready/data/pc : instruction channel (fetch unit -> decode)
//   modport master : fetch unit side; modport slave : memory/datapath side
interface ifu_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with synchronous flush, any DEPTH (pointers wrap at DEPTH).
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO (wins over push/pop)
//   push, din  : write an entry (ignored when full without a same-cycle pop)
//   pop        : drop the head entry (ignored when empty)
//   dout       : head entry, all-zero while empty
//   count      : occupancy 0..DEPTH; empty : occupancy is zero
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH = IFU_DEPTH,
    parameter type T     = ifu_entry_t
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          push,
    input  T                              din,
    input  logic                          pop,
    output T                              dout,
    output logic [ifu_cnt_w(DEPTH)-1:0]   count,
    output logic                          empty
);

    localparam int CW = ifu_cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic           full, do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Gate the head with empty so the output is defined (zero) before the first write.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? inc(wr_ptr) : wr_ptr;
            rd_ptr <= do_pop ? inc(rd_ptr) : rd_ptr;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generation, credit-limited instruction fetch and prefetch queue feeding decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ifu_if.master (memory request/response, redirect, decode handshake)
//   perf_fetch_cnt, perf_flush_cnt : saturating delivered-instruction / redirect counters,
//                                    present only when IFU_PERF_CNT_EN is defined
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          DEPTH    = IFU_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    ifu_if.master        bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetch_cnt,
    output logic [15:0]  perf_flush_cnt
`endif
);

    localparam int CW = ifu_cnt_w(DEPTH);

    ifu_state_t     state, state_nxt;
    logic [31:0]    req_pc, rsp_pc, rdr_pc;
    logic [CW-1:0]  outstanding, out_nxt, drop_cnt, drop_nxt, count;
    logic           rdr, credit, req_fire, push, pop, empty;
    ifu_entry_t     head;

    assign rdr      = bus.redirect_valid;
    assign rdr_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
    // Queued plus in-flight words never exceed DEPTH, so every response has a slot.
    assign credit   = ((CW+1)'(outstanding) + (CW+1)'(count)) < (CW+1)'(DEPTH);
    assign bus.imem_req_valid = (state == FETCH) && credit && !rdr;
    assign bus.imem_req_addr  = req_pc;
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    // drop_cnt is zero in FETCH, so any response outside FLUSH/redirect is live.
    assign push     = bus.imem_rsp_valid && (state == FETCH) && !rdr;
    assign pop      = bus.instr_valid && bus.instr_ready;
    assign out_nxt  = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    // On redirect every request still in flight after this cycle becomes stale.
    assign drop_nxt = rdr ? out_nxt
                    : (bus.imem_rsp_valid && drop_cnt != '0) ? drop_cnt - CW'(1) : drop_cnt;

    always_comb begin
        state_nxt = state;
        if (rdr)
            state_nxt = (drop_nxt != '0) ? FLUSH : FETCH;
        else if (state == IDLE)
            state_nxt = FETCH;
        else if (state == FLUSH && drop_nxt == '0)
            state_nxt = FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_pc      <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            req_pc      <= rdr ? rdr_pc : req_fire ? req_pc + 32'd4 : req_pc;
            rsp_pc      <= rdr ? rdr_pc : push ? rsp_pc + 32'd4 : rsp_pc;
            outstanding <= out_nxt;
            drop_cnt    <= drop_nxt;
        end
    end

    ifu_fifo #(.DEPTH(DEPTH), .T(ifu_entry_t)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (rdr),
        .push  (push),
        .din   ('{pc: rsp_pc, instr: bus.imem_rsp_data}),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    assign bus.instr_valid = !empty;
    assign bus.instr_data  = head.instr;
    assign bus.instr_pc    = head.pc;

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_fetch_cnt <= (pop && !(&perf_fetch_cnt)) ? perf_fetch_cnt + 32'd1 : perf_fetch_cnt;
            perf_flush_cnt <= (rdr && !(&perf_flush_cnt)) ? perf_flush_cnt + 16'd1 : perf_flush_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized and directed bench with an in-order memory model and a stream-level reference.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ifu_if bus();
`ifdef IFU_PERF_CNT_EN
    logic [31:0] pf_fetch;
    logic [15:0] pf_flush;
`endif

    instr_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (pf_fetch),
        .perf_flush_cnt (pf_flush)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          c;
    } mreq_t;

    mreq_t       memq[$];
    int          checks = 0, errors = 0, cyc = 0;
    int          lat = 1, rdy_pct = 100, ird_pct = 100, rsp_pct = 100, rdr_pct = 0;
    logic        force_rdr = 1'b0;
    logic [31:0] force_pc = '0;

    // Stream-level reference: next PC decode must see, next request address,
    // in-flight count, stale in-flight count, queued count.
    logic [31:0] exp_pc, exp_req, first_pc;
    logic        first_pend, live, p_pop, p_acc, p_push;
    int          outst, stale, qcnt, pops, flushes, p0;
    logic [31:0] popped_pc[$], popped_dat[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            chk("rst_req_addr", bus.imem_req_addr, RST_PC);
            chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
            chk("rst_instr_data", bus.instr_data, 32'd0);
            chk("rst_instr_pc", bus.instr_pc, 32'd0);
`ifdef IFU_PERF_CNT_EN
            chk("rst_perf_fetch", pf_fetch, 32'd0);
            chk("rst_perf_flush", 32'(pf_flush), 32'd0);
`endif
            exp_pc = RST_PC; exp_req = RST_PC;
            outst = 0; stale = 0; qcnt = 0; pops = 0; flushes = 0;
            live = 1'b0; first_pend = 1'b0; first_pc = 32'hFFFF_FFFF;
            popped_pc.delete(); popped_dat.delete();
        end else begin
            chk("instr_valid", 32'(bus.instr_valid), 32'(qcnt != 0));
            if (qcnt != 0) begin
                chk("instr_pc", bus.instr_pc, exp_pc);
                chk("instr_data", bus.instr_data, mem_word(exp_pc));
            end
            chk("req_valid", 32'(bus.imem_req_valid),
                32'(live && !bus.redirect_valid && stale == 0 && outst + qcnt < DEPTH));
            if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_req);
`ifdef IFU_PERF_CNT_EN
            chk("perf_fetch", pf_fetch, 32'(pops));
            chk("perf_flush", 32'(pf_flush), 32'(flushes));
`endif
            p_pop  = bus.instr_valid && bus.instr_ready;
            p_acc  = bus.imem_req_valid && bus.imem_req_ready;
            p_push = bus.imem_rsp_valid && stale == 0 && !bus.redirect_valid;
            if (p_pop) begin
                popped_pc.push_back(bus.instr_pc);
                popped_dat.push_back(bus.instr_data);
                if (first_pend) begin
                    first_pc = bus.instr_pc;
                    first_pend = 1'b0;
                end
                exp_pc += 32'd4; qcnt--; pops++;
            end
            if (bus.imem_rsp_valid) begin
                outst--;
                if (stale > 0) stale--;
            end
            if (p_acc) begin
                outst++; exp_req += 32'd4;
                memq.push_back('{bus.imem_req_addr, cyc});
            end
            if (p_push) qcnt++;
            if (bus.redirect_valid) begin
                qcnt = 0;
                exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
                exp_req = exp_pc;
                stale = outst;
                first_pend = 1'b1;
                flushes++;
            end
            live = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
        bus.instr_ready    = ($urandom_range(99) < ird_pct);
        bus.redirect_valid = force_rdr || ($urandom_range(99) < rdr_pct);
        bus.redirect_pc    = force_rdr ? force_pc : $urandom;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
        if (memq.size() > 0 && memq[0].c <= cyc - lat && $urandom_range(99) < rsp_pct) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end
        force_rdr = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        force_rdr = 1'b1;
        force_pc  = pc;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        memq.delete();
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        // Reset and first request on the second edge after release
        do_reset();
        step();
        #2;
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr", bus.imem_req_addr, RST_PC);

        // Back-to-back stream, 1-cycle memory
        repeat (9) step();
        p0 = pops;
        repeat (20) step();
        chk("stream_rate", 32'(pops - p0), 32'd20);
        chk("stream_pc1", popped_pc.size() > 1 ? popped_pc[1] : 32'hDEAD_BEEF, 32'h4);
        chk("stream_dat0", popped_dat.size() > 0 ? popped_dat[0] : 32'hDEAD_BEEF, 32'hA5A5_0000);

        // Backpressure: queue fills, credits stop requests, then drains in order
        do_reset();
        ird_pct = 0;
        repeat (10) step();
        #2;
        chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("bp_instr_valid", 32'(bus.instr_valid), 32'd1);
        chk("bp_head_pc", bus.instr_pc, 32'h0);
        chk("bp_no_pops", 32'(popped_pc.size()), 32'd0);
        ird_pct = 100;
        repeat (5) step();
        for (int i = 0; i < 4; i++)
            chk("bp_pc", popped_pc.size() > i ? popped_pc[i] : 32'hDEAD_BEEF, 32'(4 * i));

        // Redirect with two in flight, latency 3
        do_reset();
        lat = 3;
        step();
        step();
        rdy_pct = 0;
        redirect_to(32'h0000_0101);
        rdy_pct = 100;
        step();
        #2;
        chk("flush_no_req_a", 32'(bus.imem_req_valid), 32'd0);
        step();
        #2;
        chk("flush_no_req_b", 32'(bus.imem_req_valid), 32'd0);
        step();
        #2;
        chk("flush_next_req", 32'(bus.imem_req_valid), 32'd1);
        chk("flush_next_addr", bus.imem_req_addr, 32'h100);
        repeat (12) step();
        chk("flush_first_pc", first_pc, 32'h100);

        // Redirect coinciding with a response, then a second redirect two cycles later
        do_reset();
        lat = 1;
        repeat (6) step();
        redirect_to(32'h0000_0200);
        step();
        #2;
        chk("rdr_0x200_req", bus.imem_req_addr, 32'h200);
        redirect_to(32'h0000_0300);
        repeat (10) step();
        chk("rdr_first_pc", first_pc, 32'h300);

        // Asynchronous reset with three queued
        do_reset();
        ird_pct = 0;
        repeat (5) step();
        #2;
        chk("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("async_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("async_instr_pc", bus.instr_pc, 32'd0);
        ird_pct = 100;
        do_reset();
        step();
        #2;
        chk("restart_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("restart_req_addr", bus.imem_req_addr, RST_PC);

        // Randomized traffic: memory stalls, decode stalls, random redirects
        for (int s = 0; s < 4; s++) begin
            lat = $urandom_range(3, 1);
            rdy_pct = 70; ird_pct = 70; rsp_pct = 80; rdr_pct = 4;
            repeat (500) step();
        end
        rdy_pct = 100; ird_pct = 100; rsp_pct = 100; rdr_pct = 0;
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
